cpu_mem_loader: RTL and testbench
=================================

// Module: cpu_mem_loader
// PURPOSE
//   Program memory and boot loader that sits directly below SimpleCPU.
//   Holds the 2**SIZE x 32 word RAM serving the CPU's wrEn/addr_toRAM/data_toRAM/data_fromRAM port.
//   After reset it keeps the CPU in reset and accepts a byte-stream program image, writing it to RAM from address 0.
//   When the image is complete it releases the CPU; start_load re-enters load mode at any time.
// PARAMETERS
//   SIZE   10   RAM address width; depth = 2**SIZE words (matches CPU addr_toRAM width)
// PORTS
//   clk           in   1     system clock; all state changes on rising edge
//   rst           in   1     asynchronous, active-low reset
//   ld_byte       in   8     program image byte
//   ld_valid      in   1     ld_byte valid
//   ld_ready      out  1     loader can accept a byte this cycle
//   start_load    in   1     1-cycle pulse: abort run and reload image
//   cpu_rst       out  1     active-high reset to SimpleCPU (rst input)
//   load_done     out  1     image loaded, CPU running
//   load_err      out  1     image length exceeded RAM depth
//   wrEn          in   1     CPU write enable
//   addr_toRAM    in   SIZE  CPU address
//   data_toRAM    in   32    CPU write data
//   data_fromRAM  out  32    read data to CPU
// BEHAVIOUR
//   Reset (rst=0): state LEN_HI; cpu_rst=1, ld_ready=0 during reset, load_done=0, load_err=0;
//     data_fromRAM=0; wr_ptr=0; len=0. RAM contents are not cleared.
//   Byte handshake: byte consumed on rising edge with ld_valid & ld_ready; ld_ready is a decoded state output:
//     1 in LEN_HI/LEN_LO/BYTE, 0 in WRITE/RUN/ERR. ld_valid with ld_ready=0 is ignored (no buffering).
//   Image format: 16-bit word count N (big-endian, 2 bytes), then N words, 4 bytes each, MSB first.
//   FSM:
//     LEN_HI: accept -> len[15:8], -> LEN_LO.
//     LEN_LO: accept -> len[7:0]; compute N = {len[15:8], byte}:
//       N==0 -> RUN; N > 2**SIZE -> ERR; else -> BYTE with byte_cnt=0, wr_ptr=0.
//     BYTE: accept -> shift into word (first byte lands in [31:24]); byte_cnt++; on 4th byte -> WRITE.
//     WRITE: one cycle; RAM[wr_ptr] <= word; if wr_ptr==N-1 -> RUN, else wr_ptr++, byte_cnt=0, -> BYTE.
//     RUN: cpu_rst=0, load_done=1; RAM owned by CPU port.
//     ERR: load_err=1, cpu_rst=1; stays until start_load.
//   start_load (any state except reset): next state LEN_HI, cpu_rst=1, load_done=0, load_err=0,
//     wr_ptr=0, partial word discarded; takes priority over a byte accepted that same cycle.
//   cpu_rst/load_done/load_err are registered: they change on the edge that enters/leaves RUN/ERR.
//   RAM port:
//     write: in RUN, wrEn=1 writes data_toRAM to RAM[addr_toRAM] on clock edge; CPU writes outside RUN ignored.
//     Loader writes only in WRITE state.
//     read: data_fromRAM <= RAM[addr_toRAM] every cycle in all states (1-cycle registered read, read-old-data
//       on same-address write).
//   Width rules: N compared as 17-bit against 2**SIZE; N==2**SIZE legal (fills RAM, wr_ptr ends at 2**SIZE-1,
//     no wrap). Addresses beyond image keep prior contents.
//   Reset mid-load: async, returns to LEN_HI immediately; bytes already written remain in RAM.
// TESTING
//   1. Reset, send 00 02 | DE AD BE EF | 00 00 00 05 -> RAM[0]=DEADBEEF, RAM[1]=5; cpu_rst falls,
//      load_done rises 1 cycle after 2nd WRITE.
//   2. In RUN: wrEn=1, addr 0x3FF, data 0x12345678; next cycle addr 0x3FF, wrEn=0 -> data_fromRAM=12345678
//      one cycle later.
//   3. Header 04 01 (N=1025) -> ERR: load_err=1, cpu_rst=1, ld_ready=0; start_load -> LEN_HI, load_err=0.
//   4. Header 00 00 -> RUN immediately after LEN_LO byte; RAM unchanged.
//   5. start_load after 2 of 4 bytes of word 0, then valid image N=1 word 0xA5A5A5A5 -> RAM[0]=A5A5A5A5,
//      no stale bytes.
//   6. CPU wrEn=1 during load (state BYTE) -> RAM unchanged; rst pulse low mid-load -> cpu_rst=1, LEN_HI,
//      ld_ready re-asserts after release.

Source files
------------

// File: rtl/cpu_mem_loader_if.sv
// cpu_mem_loader_if: loader byte stream, CPU control/status and CPU RAM port
interface cpu_mem_loader_if #(parameter int SIZE = 10);
    logic [7:0]      ld_byte;
    logic            ld_valid;
    logic            ld_ready;
    logic            start_load;
    logic            cpu_rst;
    logic            load_done;
    logic            load_err;
    logic            wrEn;
    logic [SIZE-1:0] addr_toRAM;
    logic [31:0]     data_toRAM;
    logic [31:0]     data_fromRAM;

    modport master (
        output ld_byte, ld_valid, start_load, wrEn, addr_toRAM, data_toRAM,
        input  ld_ready, cpu_rst, load_done, load_err, data_fromRAM
    );

    modport slave (
        input  ld_byte, ld_valid, start_load, wrEn, addr_toRAM, data_toRAM,
        output ld_ready, cpu_rst, load_done, load_err, data_fromRAM
    );
endinterface

// File: rtl/cpu_mem_loader.sv
// cpu_mem_loader: program RAM plus byte-stream boot loader that holds the CPU in reset until the image is in
module cpu_mem_loader #(parameter int SIZE = 10) (
    input logic             clk,
    input logic             rst,
    cpu_mem_loader_if.slave bus
);
    typedef enum logic [2:0] {LEN_HI, LEN_LO, BYTE, WRITE, RUN, ERR} state_t;

    localparam logic [16:0] DEPTH = 17'(2**SIZE);

    state_t          state_q, state_d;
    logic [15:0]     len_q, len_d;
    logic [SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [31:0]     word_q, word_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            cpu_rst_q, cpu_rst_d;
    logic            load_done_q, load_done_d;
    logic            load_err_q, load_err_d;
    logic [31:0]     mem [2**SIZE];
    logic            accept;
    logic [16:0]     n_hdr;

    // ld_ready is forced low while reset is held even though the state already reads LEN_HI
    assign bus.ld_ready     = rst && (state_q inside {LEN_HI, LEN_LO, BYTE});
    assign accept           = bus.ld_valid && bus.ld_ready;
    assign n_hdr            = {1'b0, len_q[15:8], bus.ld_byte};
    assign bus.cpu_rst      = cpu_rst_q;
    assign bus.load_done    = load_done_q;
    assign bus.load_err     = load_err_q;
    assign bus.data_fromRAM = rdata_q;

    // loader next state; start_load overrides any byte accepted in the same cycle
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        wr_ptr_d   = wr_ptr_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        rdata_d    = mem[bus.addr_toRAM];
        case (state_q)
            LEN_HI: if (accept) begin
                len_d[15:8] = bus.ld_byte;
                state_d     = LEN_LO;
            end
            LEN_LO: if (accept) begin
                len_d[7:0] = bus.ld_byte;
                wr_ptr_d   = '0;
                byte_cnt_d = '0;
                state_d    = (n_hdr == 17'd0) ? RUN : (n_hdr > DEPTH) ? ERR : BYTE;
            end
            BYTE: if (accept) begin
                word_d     = {word_q[23:0], bus.ld_byte};
                byte_cnt_d = byte_cnt_q + 2'd1;
                state_d    = (byte_cnt_q == 2'd3) ? WRITE : BYTE;
            end
            WRITE: begin
                byte_cnt_d = '0;
                wr_ptr_d   = ({1'b0, len_q} - 17'd1 == 17'(wr_ptr_q)) ? wr_ptr_q : wr_ptr_q + SIZE'(1);
                state_d    = ({1'b0, len_q} - 17'd1 == 17'(wr_ptr_q)) ? RUN : BYTE;
            end
            default: ;
        endcase
        if (bus.start_load) begin
            state_d    = LEN_HI;
            wr_ptr_d   = '0;
            byte_cnt_d = '0;
            word_d     = '0;
        end
        cpu_rst_d   = state_d != RUN;
        load_done_d = state_d == RUN;
        load_err_d  = state_d == ERR;
    end

    // loader state, status flags and registered read data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= LEN_HI;
            len_q       <= '0;
            wr_ptr_q    <= '0;
            byte_cnt_q  <= '0;
            word_q      <= '0;
            rdata_q     <= '0;
            cpu_rst_q   <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wr_ptr_q    <= wr_ptr_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            rdata_q     <= rdata_d;
            cpu_rst_q   <= cpu_rst_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    // RAM write port: loader owns it in WRITE, the CPU only while running
    always_ff @(posedge clk) begin
        if (state_q == WRITE)
            mem[wr_ptr_q] <= word_q;
        else if (state_q == RUN && bus.wrEn)
            mem[bus.addr_toRAM] <= bus.data_toRAM;
    end
endmodule

// File: tb/tb_cpu_mem_loader.sv
// tb_cpu_mem_loader: randomized scenarios against an array model of the program RAM
module tb_cpu_mem_loader;
    localparam int SIZE  = 10;
    localparam int DEPTH = 1 << SIZE;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    logic [31:0] ram_m [DEPTH];

    cpu_mem_loader_if #(.SIZE(SIZE)) bus();
    cpu_mem_loader #(.SIZE(SIZE)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        repeat ($urandom_range(0, 1)) tick();
        bus.ld_byte  = b;
        bus.ld_valid = 1'b1;
        t = 0;
        while (!bus.ld_ready && t < 20) begin
            tick();
            t++;
        end
        if (t >= 20) begin
            vectors++;
            miscompares++;
            $display("FAIL ld_ready_timeout: got 0 want 1");
        end
        tick();
        bus.ld_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
    endtask

    task automatic send_image(input logic [31:0] w[$]);
        logic [15:0] n;
        n = 16'(w.size());
        send_byte(n[15:8]);
        send_byte(n[7:0]);
        foreach (w[i]) send_word(w[i]);
    endtask

    task automatic model_load(input logic [31:0] w[$]);
        foreach (w[i]) ram_m[i] = w[i];
    endtask

    task automatic wait_done();
        int t = 0;
        while (!bus.load_done && t < 10) begin
            tick();
            t++;
        end
        vectors++;
        if (bus.load_done !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_load_done: got %b want 1", bus.load_done);
        end
    endtask

    task automatic start_pulse();
        bus.start_load = 1'b1;
        tick();
        bus.start_load = 1'b0;
    endtask

    task automatic read_word(input logic [SIZE-1:0] a, output logic [31:0] d);
        bus.addr_toRAM = a;
        tick();
        d = bus.data_fromRAM;
    endtask

    task automatic cpu_write(input logic [SIZE-1:0] a, input logic [31:0] d);
        bus.wrEn       = 1'b1;
        bus.addr_toRAM = a;
        bus.data_toRAM = d;
        tick();
        bus.wrEn = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        vectors += 5;
        if (bus.cpu_rst !== 1'b1) begin miscompares++; $display("FAIL rst_cpu_rst: got %b want 1", bus.cpu_rst); end
        if (bus.ld_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ld_ready: got %b want 0", bus.ld_ready); end
        if (bus.load_done !== 1'b0) begin miscompares++; $display("FAIL rst_load_done: got %b want 0", bus.load_done); end
        if (bus.load_err !== 1'b0) begin miscompares++; $display("FAIL rst_load_err: got %b want 0", bus.load_err); end
        if (bus.data_fromRAM !== 32'h0) begin miscompares++; $display("FAIL rst_rdata: got %h want 0", bus.data_fromRAM); end
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.ld_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_ld_ready: got %b want 1", bus.ld_ready); end
    endtask

    task automatic test_load_basic();
        logic [31:0] w[$];
        logic [31:0] d;
        w = '{32'hDEADBEEF, 32'h00000005};
        send_image(w);
        vectors += 3;
        if (bus.load_done !== 1'b0) begin miscompares++; $display("FAIL basic_done_early: got %b want 0", bus.load_done); end
        if (bus.cpu_rst !== 1'b1) begin miscompares++; $display("FAIL basic_cpu_rst_early: got %b want 1", bus.cpu_rst); end
        if (bus.ld_ready !== 1'b0) begin miscompares++; $display("FAIL basic_ready_in_write: got %b want 0", bus.ld_ready); end
        tick();
        vectors += 2;
        if (bus.load_done !== 1'b1) begin miscompares++; $display("FAIL basic_done: got %b want 1", bus.load_done); end
        if (bus.cpu_rst !== 1'b0) begin miscompares++; $display("FAIL basic_cpu_rst: got %b want 0", bus.cpu_rst); end
        model_load(w);
        for (int i = 0; i < 2; i++) begin
            read_word(SIZE'(i), d);
            vectors++;
            if (d !== ram_m[i]) begin miscompares++; $display("FAIL basic_ram[%0d]: got %h want %h", i, d, ram_m[i]); end
        end
    endtask

    task automatic test_full();
        logic [31:0] w[$];
        logic [31:0] d;
        int err = 0;
        start_pulse();
        for (int i = 0; i < DEPTH; i++) w.push_back($urandom);
        send_image(w);
        wait_done();
        model_load(w);
        for (int i = 0; i < DEPTH; i++) begin
            read_word(SIZE'(i), d);
            vectors++;
            if (d !== ram_m[i]) begin
                miscompares++;
                if (err++ < 8) $display("FAIL full_ram[%0d]: got %h want %h", i, d, ram_m[i]);
            end
        end
    endtask

    task automatic test_cpu_write();
        logic [31:0] d;
        logic [31:0] nd;
        logic [SIZE-1:0] a;
        cpu_write(SIZE'(10'h3FF), 32'h12345678);
        ram_m[DEPTH-1] = 32'h12345678;
        read_word(SIZE'(10'h3FF), d);
        vectors++;
        if (d !== 32'h12345678) begin miscompares++; $display("FAIL cpu_wr_3ff: got %h want 12345678", d); end
        nd = $urandom;
        cpu_write(SIZE'(10'h3FF), nd);
        vectors++;
        if (bus.data_fromRAM !== 32'h12345678) begin miscompares++; $display("FAIL read_old_data: got %h want 12345678", bus.data_fromRAM); end
        ram_m[DEPTH-1] = nd;
        read_word(SIZE'(10'h3FF), d);
        vectors++;
        if (d !== nd) begin miscompares++; $display("FAIL read_new_data: got %h want %h", d, nd); end
        for (int i = 0; i < 8; i++) begin
            a  = SIZE'($urandom);
            nd = $urandom;
            cpu_write(a, nd);
            ram_m[a] = nd;
            read_word(a, d);
            vectors++;
            if (d !== ram_m[a]) begin miscompares++; $display("FAIL cpu_wr_rand[%0d]: got %h want %h", a, d, ram_m[a]); end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        start_pulse();
        vectors += 2;
        if (bus.load_done !== 1'b0) begin miscompares++; $display("FAIL start_load_done: got %b want 0", bus.load_done); end
        if (bus.cpu_rst !== 1'b1) begin miscompares++; $display("FAIL start_cpu_rst: got %b want 1", bus.cpu_rst); end
        send_byte(8'h04);
        send_byte(8'h01);
        vectors += 4;
        if (bus.load_err !== 1'b1) begin miscompares++; $display("FAIL ovf_load_err: got %b want 1", bus.load_err); end
        if (bus.cpu_rst !== 1'b1) begin miscompares++; $display("FAIL ovf_cpu_rst: got %b want 1", bus.cpu_rst); end
        if (bus.ld_ready !== 1'b0) begin miscompares++; $display("FAIL ovf_ld_ready: got %b want 0", bus.ld_ready); end
        if (bus.load_done !== 1'b0) begin miscompares++; $display("FAIL ovf_load_done: got %b want 0", bus.load_done); end
        bus.ld_byte  = 8'h55;
        bus.ld_valid = 1'b1;
        repeat (3) tick();
        bus.ld_valid = 1'b0;
        vectors++;
        if (bus.load_err !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b want 1", bus.load_err); end
        read_word(SIZE'(0), d);
        vectors++;
        if (d !== ram_m[0]) begin miscompares++; $display("FAIL ovf_ram0: got %h want %h", d, ram_m[0]); end
        start_pulse();
        vectors += 2;
        if (bus.load_err !== 1'b0) begin miscompares++; $display("FAIL ovf_clear: got %b want 0", bus.load_err); end
        if (bus.ld_ready !== 1'b1) begin miscompares++; $display("FAIL ovf_ready_back: got %b want 1", bus.ld_ready); end
    endtask

    task automatic test_zero_len();
        logic [31:0] d;
        logic [SIZE-1:0] a;
        start_pulse();
        send_byte(8'h00);
        send_byte(8'h00);
        vectors += 2;
        if (bus.load_done !== 1'b1) begin miscompares++; $display("FAIL zero_done: got %b want 1", bus.load_done); end
        if (bus.cpu_rst !== 1'b0) begin miscompares++; $display("FAIL zero_cpu_rst: got %b want 0", bus.cpu_rst); end
        for (int i = 0; i < 6; i++) begin
            a = (i == 0) ? SIZE'(0) : SIZE'($urandom);
            read_word(a, d);
            vectors++;
            if (d !== ram_m[a]) begin miscompares++; $display("FAIL zero_ram[%0d]: got %h want %h", a, d, ram_m[a]); end
        end
    endtask

    task automatic test_abort();
        logic [31:0] w[$];
        logic [31:0] d;
        start_pulse();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        bus.ld_byte    = 8'h00;
        bus.ld_valid   = 1'b1;
        bus.start_load = 1'b1;
        tick();
        bus.ld_valid   = 1'b0;
        bus.start_load = 1'b0;
        send_byte(8'h00);
        send_byte(8'h01);
        vectors += 2;
        if (bus.load_done !== 1'b0) begin miscompares++; $display("FAIL abort_priority_done: got %b want 0", bus.load_done); end
        if (bus.ld_ready !== 1'b1) begin miscompares++; $display("FAIL abort_ready: got %b want 1", bus.ld_ready); end
        send_word(32'hA5A5A5A5);
        wait_done();
        w = '{32'hA5A5A5A5};
        model_load(w);
        for (int i = 0; i < 2; i++) begin
            read_word(SIZE'(i), d);
            vectors++;
            if (d !== ram_m[i]) begin miscompares++; $display("FAIL abort_ram[%0d]: got %h want %h", i, d, ram_m[i]); end
        end
    endtask

    task automatic test_load_protect();
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] d;
        w0 = $urandom;
        w1 = $urandom;
        start_pulse();
        send_byte(8'h00);
        send_byte(8'h03);
        send_word(w0);
        send_byte(w1[31:24]);
        cpu_write(SIZE'(10'h200), ~ram_m[10'h200]);
        send_byte(w1[23:16]);
        send_byte(w1[15:8]);
        send_byte(w1[7:0]);
        send_byte(8'hC3);
        send_byte(8'h3C);
        #2 rst = 1'b0;
        #1;
        vectors += 4;
        if (bus.cpu_rst !== 1'b1) begin miscompares++; $display("FAIL midrst_cpu_rst: got %b want 1", bus.cpu_rst); end
        if (bus.ld_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_ld_ready: got %b want 0", bus.ld_ready); end
        if (bus.load_done !== 1'b0) begin miscompares++; $display("FAIL midrst_load_done: got %b want 0", bus.load_done); end
        if (bus.data_fromRAM !== 32'h0) begin miscompares++; $display("FAIL midrst_rdata: got %h want 0", bus.data_fromRAM); end
        tick();
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.ld_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready_back: got %b want 1", bus.ld_ready); end
        ram_m[0] = w0;
        ram_m[1] = w1;
        read_word(SIZE'(0), d);
        vectors++;
        if (d !== ram_m[0]) begin miscompares++; $display("FAIL midrst_ram0: got %h want %h", d, ram_m[0]); end
        read_word(SIZE'(1), d);
        vectors++;
        if (d !== ram_m[1]) begin miscompares++; $display("FAIL midrst_ram1: got %h want %h", d, ram_m[1]); end
        read_word(SIZE'(2), d);
        vectors++;
        if (d !== ram_m[2]) begin miscompares++; $display("FAIL midrst_ram2: got %h want %h", d, ram_m[2]); end
        read_word(SIZE'(10'h200), d);
        vectors++;
        if (d !== ram_m[10'h200]) begin miscompares++; $display("FAIL cpu_wr_in_load: got %h want %h", d, ram_m[10'h200]); end
    endtask

    task automatic test_random();
        logic [31:0] w[$];
        logic [31:0] d;
        logic [SIZE-1:0] a;
        int n;
        for (int it = 0; it < 6; it++) begin
            w.delete();
            n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++) w.push_back($urandom);
            start_pulse();
            send_image(w);
            wait_done();
            model_load(w);
            for (int i = 0; i <= n; i++) begin
                a = (i == n) ? SIZE'($urandom_range(n, DEPTH - 1)) : SIZE'(i);
                read_word(a, d);
                vectors++;
                if (d !== ram_m[a]) begin miscompares++; $display("FAIL rand%0d_ram[%0d]: got %h want %h", it, a, d, ram_m[a]); end
            end
        end
    endtask

    initial begin
        bus.ld_byte    = '0;
        bus.ld_valid   = 1'b0;
        bus.start_load = 1'b0;
        bus.wrEn       = 1'b0;
        bus.addr_toRAM = '0;
        bus.data_toRAM = '0;
        test_reset();
        test_load_basic();
        test_full();
        test_cpu_write();
        test_overflow();
        test_zero_len();
        test_abort();
        test_load_protect();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
